// File: rtl/dpm_arb_pkg.sv
// Shared types and helpers for the dual-port bank arbiter and its read trackers.
package dpm_arb_pkg;

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

    localparam int NUM_BANK_DEF = 4;
    localparam int BANK_BITS    = $clog2(NUM_BANK_DEF);

    // Bank index = the top bank_bits bits of an addr_width-bit address.
    function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                            input int          addr_width,
                                            input int          bank_bits);
        return (addr >> (addr_width - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/dpm_rd_tracker.sv
// Read-return tracker: delays read-issue flags and gates memory data onto rdata.
// Latency READ_LATENCY cycles from issue; no backpressure, one response per issued read.
module dpm_rd_tracker #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    logic [READ_LATENCY-1:0] pipe;

    generate
        if (READ_LATENCY == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe <= '0;
                else        pipe <= issue;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe <= '0;
                else        pipe <= {pipe[READ_LATENCY-2:0], issue};
            end
        end
    endgenerate

    assign rvalid = pipe[READ_LATENCY-1];
    assign rdata  = rvalid ? mem_dout : '0;

endmodule

// File: rtl/dpm_bank_arbiter.sv
// Two-requester bank arbiter for a dual-port banked memory (counters under DPM_ARB_PERF_EN).
// Latency: memory command 1 cycle after accept, read data 1+READ_LATENCY cycles after accept.
// Backpressure: on a same-bank clash only the round-robin holder is ready; the loser holds.
module dpm_bank_arbiter
    import dpm_arb_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_BANK     = NUM_BANK_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid_a,
    output logic                  o_req_ready_a,
    input  logic                  i_req_we_a,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_a,
    input  logic [WIDTH-1:0]      i_req_wdata_a,
    output logic                  o_rvalid_a,
    output logic [WIDTH-1:0]      o_rdata_a,
    input  logic                  i_req_valid_b,
    output logic                  o_req_ready_b,
    input  logic                  i_req_we_b,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_b,
    input  logic [WIDTH-1:0]      i_req_wdata_b,
    output logic                  o_rvalid_b,
    output logic [WIDTH-1:0]      o_rdata_b,
    output logic                  o_mem_en_a,
    output logic                  o_mem_we_a,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_a,
    output logic [WIDTH-1:0]      o_mem_din_a,
    input  logic [WIDTH-1:0]      i_mem_dout_a,
    output logic                  o_mem_en_b,
    output logic                  o_mem_we_b,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_b,
    output logic [WIDTH-1:0]      o_mem_din_b,
    input  logic [WIDTH-1:0]      i_mem_dout_b
`ifdef DPM_ARB_PERF_EN
    ,
    output logic [15:0]           o_conflict_cnt,
    output logic [15:0]           o_stall_cnt_a,
    output logic [15:0]           o_stall_cnt_b
`endif
);

    localparam int BANK_W = $clog2(NUM_BANK);

    pri_t        pri;
    pri_t        pri_next;
    logic        conflict;
    logic [31:0] bank_a;
    logic [31:0] bank_b;

    assign bank_a   = bank_of(32'(i_req_addr_a), ADDR_WIDTH, BANK_W);
    assign bank_b   = bank_of(32'(i_req_addr_b), ADDR_WIDTH, BANK_W);
    assign conflict = i_req_valid_a && i_req_valid_b && (bank_a == bank_b);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pri <= PRI_A;
        else          pri <= pri_next;
    end

    // Priority flips only when it was actually used to break a tie.
    always_comb begin
        pri_next = pri;
        if (conflict) pri_next = (pri == PRI_A) ? PRI_B : PRI_A;
    end

    always_comb begin
        o_req_ready_a = i_rst_n && i_req_valid_a && (!conflict || pri == PRI_A);
        o_req_ready_b = i_rst_n && i_req_valid_b && (!conflict || pri == PRI_B);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_en_a   <= 1'b0;
            o_mem_we_a   <= 1'b0;
            o_mem_addr_a <= '0;
            o_mem_din_a  <= '0;
        end else begin
            o_mem_en_a <= o_req_ready_a;
            o_mem_we_a <= o_req_ready_a && i_req_we_a;
            if (o_req_ready_a) begin
                o_mem_addr_a <= i_req_addr_a;
                o_mem_din_a  <= i_req_wdata_a;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_en_b   <= 1'b0;
            o_mem_we_b   <= 1'b0;
            o_mem_addr_b <= '0;
            o_mem_din_b  <= '0;
        end else begin
            o_mem_en_b <= o_req_ready_b;
            o_mem_we_b <= o_req_ready_b && i_req_we_b;
            if (o_req_ready_b) begin
                o_mem_addr_b <= i_req_addr_b;
                o_mem_din_b  <= i_req_wdata_b;
            end
        end
    end

    dpm_rd_tracker #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_trk_a (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .issue    (o_mem_en_a && !o_mem_we_a),
        .mem_dout (i_mem_dout_a),
        .rvalid   (o_rvalid_a),
        .rdata    (o_rdata_a)
    );

    dpm_rd_tracker #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_trk_b (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .issue    (o_mem_en_b && !o_mem_we_b),
        .mem_dout (i_mem_dout_b),
        .rvalid   (o_rvalid_b),
        .rdata    (o_rdata_b)
    );

`ifdef DPM_ARB_PERF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_conflict_cnt <= '0;
            o_stall_cnt_a  <= '0;
            o_stall_cnt_b  <= '0;
        end else begin
            if (conflict && o_conflict_cnt != 16'hFFFF)
                o_conflict_cnt <= o_conflict_cnt + 16'd1;
            if (i_req_valid_a && !o_req_ready_a && o_stall_cnt_a != 16'hFFFF)
                o_stall_cnt_a <= o_stall_cnt_a + 16'd1;
            if (i_req_valid_b && !o_req_ready_b && o_stall_cnt_b != 16'hFFFF)
                o_stall_cnt_b <= o_stall_cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpm_bank_arbiter.sv
// Randomized self-checking bench for dpm_bank_arbiter against a transaction-level model.
module tb_dpm_bank_arbiter;

    localparam int W  = 8;
    localparam int AW = 5;
    localparam int NB = 4;
    localparam int RL = 3;
    localparam int BANK_SIZE = (1 << AW) / NB;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_req_valid_a = 1'b0, i_req_we_a = 1'b0;
    logic [AW-1:0] i_req_addr_a = '0;
    logic [W-1:0]  i_req_wdata_a = '0;
    logic          i_req_valid_b = 1'b0, i_req_we_b = 1'b0;
    logic [AW-1:0] i_req_addr_b = '0;
    logic [W-1:0]  i_req_wdata_b = '0;
    logic          o_req_ready_a, o_req_ready_b, o_rvalid_a, o_rvalid_b;
    logic [W-1:0]  o_rdata_a, o_rdata_b;
    logic          o_mem_en_a, o_mem_we_a, o_mem_en_b, o_mem_we_b;
    logic [AW-1:0] o_mem_addr_a, o_mem_addr_b;
    logic [W-1:0]  o_mem_din_a, o_mem_din_b;
    logic [W-1:0]  i_mem_dout_a, i_mem_dout_b;
`ifdef DPM_ARB_PERF_EN
    logic [15:0]   o_conflict_cnt, o_stall_cnt_a, o_stall_cnt_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 i_clk = ~i_clk;

    dpm_bank_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_BANK(NB), .READ_LATENCY(RL)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid_a(i_req_valid_a), .o_req_ready_a(o_req_ready_a), .i_req_we_a(i_req_we_a),
        .i_req_addr_a(i_req_addr_a), .i_req_wdata_a(i_req_wdata_a),
        .o_rvalid_a(o_rvalid_a), .o_rdata_a(o_rdata_a),
        .i_req_valid_b(i_req_valid_b), .o_req_ready_b(o_req_ready_b), .i_req_we_b(i_req_we_b),
        .i_req_addr_b(i_req_addr_b), .i_req_wdata_b(i_req_wdata_b),
        .o_rvalid_b(o_rvalid_b), .o_rdata_b(o_rdata_b),
        .o_mem_en_a(o_mem_en_a), .o_mem_we_a(o_mem_we_a), .o_mem_addr_a(o_mem_addr_a),
        .o_mem_din_a(o_mem_din_a), .i_mem_dout_a(i_mem_dout_a),
        .o_mem_en_b(o_mem_en_b), .o_mem_we_b(o_mem_we_b), .o_mem_addr_b(o_mem_addr_b),
        .o_mem_din_b(o_mem_din_b), .i_mem_dout_b(i_mem_dout_b)
`ifdef DPM_ARB_PERF_EN
        , .o_conflict_cnt(o_conflict_cnt), .o_stall_cnt_a(o_stall_cnt_a), .o_stall_cnt_b(o_stall_cnt_b)
`endif
    );

    // Memory model: a read of addr returns addr^0x5A after RL cycles; idle slots return 0xEE.
    logic [W-1:0] mpipe_a [RL];
    logic [W-1:0] mpipe_b [RL];
    initial begin
        for (int i = 0; i < RL; i++) begin
            mpipe_a[i] = 8'hEE;
            mpipe_b[i] = 8'hEE;
        end
    end
    always @(posedge i_clk) begin
        for (int i = RL - 1; i > 0; i--) begin
            mpipe_a[i] <= mpipe_a[i-1];
            mpipe_b[i] <= mpipe_b[i-1];
        end
        mpipe_a[0] <= (o_mem_en_a && !o_mem_we_a) ? ({3'b000, o_mem_addr_a} ^ 8'h5A) : 8'hEE;
        mpipe_b[0] <= (o_mem_en_b && !o_mem_we_b) ? ({3'b000, o_mem_addr_b} ^ 8'h5A) : 8'hEE;
    end
    assign i_mem_dout_a = mpipe_a[RL-1];
    assign i_mem_dout_b = mpipe_b[RL-1];

    // Reference model: who wins the next tie, the memory command seen this cycle, scheduled responses.
    bit            m_b_wins;
    logic          m_en_a, m_we_a, m_en_b, m_we_b;
    logic [AW-1:0] m_addr_a, m_addr_b;
    logic [W-1:0]  m_din_a, m_din_b;
    logic [W-1:0]  exp_rd_a [int];
    logic [W-1:0]  exp_rd_b [int];

    function automatic int bank(input logic [AW-1:0] a);
        return int'(a) / BANK_SIZE;
    endfunction

    function automatic void model_reset();
        m_b_wins = 1'b0;
        m_en_a = 1'b0; m_we_a = 1'b0; m_addr_a = '0; m_din_a = '0;
        m_en_b = 1'b0; m_we_b = 1'b0; m_addr_b = '0; m_din_b = '0;
        exp_rd_a.delete();
        exp_rd_b.delete();
    endfunction

    // Called at a falling edge with inputs already driven; checks this cycle, advances to the next.
    task automatic step(output bit ga, output bit gb, output logic ra, output logic rb);
        bit           conf, ea, eb, erv_a, erv_b;
        logic [W-1:0] erd_a, erd_b;
        #1;
        if (!i_rst_n) model_reset();
        conf = i_req_valid_a && i_req_valid_b && (bank(i_req_addr_a) == bank(i_req_addr_b));
        ea = i_rst_n && i_req_valid_a && (!conf || !m_b_wins);
        eb = i_rst_n && i_req_valid_b && (!conf || m_b_wins);
        ra = o_req_ready_a;
        rb = o_req_ready_b;
        erv_a = exp_rd_a.exists(cyc);
        erv_b = exp_rd_b.exists(cyc);
        erd_a = erv_a ? exp_rd_a[cyc] : '0;
        erd_b = erv_b ? exp_rd_b[cyc] : '0;

        checks++;
        if (o_req_ready_a !== ea) begin
            errors++; $display("FAIL ready_a cyc %0d got %b exp %b", cyc, o_req_ready_a, ea);
        end
        checks++;
        if (o_req_ready_b !== eb) begin
            errors++; $display("FAIL ready_b cyc %0d got %b exp %b", cyc, o_req_ready_b, eb);
        end
        checks++;
        if ({o_mem_en_a, o_mem_we_a, o_mem_addr_a, o_mem_din_a} !== {m_en_a, m_we_a, m_addr_a, m_din_a}) begin
            errors++;
            $display("FAIL mem_a cyc %0d got en%b we%b a%h d%h exp en%b we%b a%h d%h", cyc,
                     o_mem_en_a, o_mem_we_a, o_mem_addr_a, o_mem_din_a, m_en_a, m_we_a, m_addr_a, m_din_a);
        end
        checks++;
        if ({o_mem_en_b, o_mem_we_b, o_mem_addr_b, o_mem_din_b} !== {m_en_b, m_we_b, m_addr_b, m_din_b}) begin
            errors++;
            $display("FAIL mem_b cyc %0d got en%b we%b a%h d%h exp en%b we%b a%h d%h", cyc,
                     o_mem_en_b, o_mem_we_b, o_mem_addr_b, o_mem_din_b, m_en_b, m_we_b, m_addr_b, m_din_b);
        end
        checks++;
        if ({o_rvalid_a, o_rdata_a} !== {erv_a, erd_a}) begin
            errors++; $display("FAIL rsp_a cyc %0d got v%b d%h exp v%b d%h", cyc, o_rvalid_a, o_rdata_a, erv_a, erd_a);
        end
        checks++;
        if ({o_rvalid_b, o_rdata_b} !== {erv_b, erd_b}) begin
            errors++; $display("FAIL rsp_b cyc %0d got v%b d%h exp v%b d%h", cyc, o_rvalid_b, o_rdata_b, erv_b, erd_b);
        end

        exp_rd_a.delete(cyc);
        exp_rd_b.delete(cyc);
        if (i_rst_n) begin
            m_en_a = ea; m_we_a = ea && i_req_we_a;
            if (ea) begin
                m_addr_a = i_req_addr_a; m_din_a = i_req_wdata_a;
                if (!i_req_we_a) exp_rd_a[cyc + 1 + RL] = {3'b000, i_req_addr_a} ^ 8'h5A;
            end
            m_en_b = eb; m_we_b = eb && i_req_we_b;
            if (eb) begin
                m_addr_b = i_req_addr_b; m_din_b = i_req_wdata_b;
                if (!i_req_we_b) exp_rd_b[cyc + 1 + RL] = {3'b000, i_req_addr_b} ^ 8'h5A;
            end
            if (conf) m_b_wins = !m_b_wins;
        end
        ga = ea;
        gb = eb;
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit ga, gb;
        logic ra, rb;
        i_req_valid_a = 1'b0;
        i_req_valid_b = 1'b0;
        for (int i = 0; i < n; i++) step(ga, gb, ra, rb);
    endtask

    task automatic test_reset();
        bit ga, gb;
        logic ra, rb;
        i_rst_n = 1'b0;
        i_req_valid_a = 1'b1; i_req_addr_a = 5'h08;
        i_req_valid_b = 1'b1; i_req_addr_b = 5'h08;
        step(ga, gb, ra, rb);
        step(ga, gb, ra, rb);
        i_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_no_conflict();
        bit ga, gb;
        logic ra, rb;
        i_req_valid_a = 1'b1; i_req_we_a = 1'b1; i_req_addr_a = 5'h03; i_req_wdata_a = 8'hA5;
        i_req_valid_b = 1'b1; i_req_we_b = 1'b0; i_req_addr_b = 5'h1C; i_req_wdata_b = 8'h00;
        step(ga, gb, ra, rb);
        checks++;
        if ({ra, rb} !== 2'b11) begin
            errors++; $display("FAIL no_conflict_ready got %b exp 11", {ra, rb});
        end
        idle(RL + 3);
    endtask

    task automatic test_conflict_rr();
        bit ga, gb;
        logic ra, rb;
        logic [3:0] pat_a, pat_b;
        pat_a = 4'b0101;
        pat_b = 4'b1010;
        i_req_valid_a = 1'b1; i_req_we_a = 1'b0; i_req_addr_a = 5'h08;
        i_req_valid_b = 1'b1; i_req_we_b = 1'b0; i_req_addr_b = 5'h0C;
        for (int i = 0; i < 4; i++) begin
            step(ga, gb, ra, rb);
            checks++;
            if ({ra, rb} !== {pat_a[i], pat_b[i]}) begin
                errors++; $display("FAIL rr_order slot %0d got %b%b exp %b%b", i, ra, rb, pat_a[i], pat_b[i]);
            end
        end
        idle(RL + 3);
    endtask

    task automatic test_same_addr_write();
        bit ga, gb;
        logic ra, rb;
        i_req_valid_a = 1'b1; i_req_we_a = 1'b1; i_req_addr_a = 5'h10; i_req_wdata_a = 8'h11;
        i_req_valid_b = 1'b1; i_req_we_b = 1'b1; i_req_addr_b = 5'h10; i_req_wdata_b = 8'h22;
        step(ga, gb, ra, rb);
        checks++;
        if ({ra, rb} !== 2'b10) begin
            errors++; $display("FAIL same_addr_first got %b exp 10", {ra, rb});
        end
        i_req_valid_a = 1'b0;
        step(ga, gb, ra, rb);
        checks++;
        if ({ra, rb} !== 2'b01) begin
            errors++; $display("FAIL same_addr_second got %b exp 01", {ra, rb});
        end
        idle(3);
    endtask

    task automatic test_stream();
        bit ga, gb;
        logic ra, rb;
        int cnt, first, last;
        cnt = 0; first = -1; last = -1;
        i_req_valid_b = 1'b0;
        for (int k = 0; k < 8 + RL + 4; k++) begin
            i_req_valid_a = (k < 8);
            i_req_we_a    = 1'b0;
            i_req_addr_a  = AW'(3 * k + 1);
            step(ga, gb, ra, rb);
            if (o_rvalid_a === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        checks++;
        if (cnt != 8 || last - first != 7) begin
            errors++; $display("FAIL stream_burst got %0d rvalids over span %0d exp 8 over 7", cnt, last - first);
        end
    endtask

    task automatic test_random();
        bit ga, gb, pend_a, pend_b;
        logic ra, rb;
        logic [31:0] r;
        pend_a = 1'b0; pend_b = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend_a) begin
                r = $urandom;
                pend_a = (r[1:0] != 2'b00);
                i_req_we_a = r[2]; i_req_addr_a = r[12:8]; i_req_wdata_a = r[23:16];
            end
            if (!pend_b) begin
                r = $urandom;
                pend_b = (r[1:0] != 2'b00);
                i_req_we_b = r[2]; i_req_addr_b = r[12:8]; i_req_wdata_b = r[23:16];
            end
            i_req_valid_a = pend_a;
            i_req_valid_b = pend_b;
            step(ga, gb, ra, rb);
            if (ga) pend_a = 1'b0;
            if (gb) pend_b = 1'b0;
        end
        idle(RL + 3);
    endtask

    task automatic test_reset_inflight();
        bit ga, gb;
        logic ra, rb;
        int seen;
        seen = 0;
        i_req_valid_b = 1'b0;
        i_req_valid_a = 1'b1; i_req_we_a = 1'b0; i_req_addr_a = 5'h05;
        step(ga, gb, ra, rb);
        i_req_addr_a = 5'h06;
        step(ga, gb, ra, rb);
        i_req_valid_a = 1'b0;
        i_rst_n = 1'b0;
        step(ga, gb, ra, rb);
        i_rst_n = 1'b1;
        for (int k = 0; k < RL + 4; k++) begin
            step(ga, gb, ra, rb);
            if (o_rvalid_a !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_drop got %0d rvalids exp 0", seen);
        end
    endtask

    task automatic test_perf();
`ifdef DPM_ARB_PERF_EN
        bit ga, gb;
        logic ra, rb;
        i_req_valid_a = 1'b0; i_req_valid_b = 1'b0;
        i_rst_n = 1'b0;
        step(ga, gb, ra, rb);
        i_rst_n = 1'b1;
        step(ga, gb, ra, rb);
        i_req_valid_a = 1'b1; i_req_we_a = 1'b0; i_req_addr_a = 5'h00;
        i_req_valid_b = 1'b1; i_req_we_b = 1'b0; i_req_addr_b = 5'h04;
        for (int i = 0; i < 5; i++) step(ga, gb, ra, rb);
        i_req_valid_a = 1'b0; i_req_valid_b = 1'b0;
        checks++;
        if ({o_conflict_cnt, o_stall_cnt_a, o_stall_cnt_b} !== {16'd5, 16'd2, 16'd3}) begin
            errors++;
            $display("FAIL perf_cnt got c%0d sa%0d sb%0d exp c5 sa2 sb3", o_conflict_cnt, o_stall_cnt_a, o_stall_cnt_b);
        end
        idle(RL + 3);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d exceeded time budget", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_no_conflict();
        test_conflict_rr();
        test_same_addr_write();
        test_stream();
        test_random();
        test_reset_inflight();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpm_bank_arbiter.md
Name: dpm_bank_arbiter

Overview:
Single-clock arbiter and sequencer for the two ports of the dual-port multi-bank memory.
- Two requesters (A, B) present valid/ready read/write requests.
- The block forwards them onto memory ports A and B. When both target the same bank in the same cycle, it serializes them with round-robin priority.
- It tracks read latency and returns read data with a per-port rvalid strobe.

Parameters:
WIDTH, 8, data width per word
ADDR_WIDTH, 5, total address width; bank select = top log2(NUM_BANK) bits
NUM_BANK, 4, number of banks (power of two, >=2)
READ_LATENCY, 1, cycles from memory enable to valid memory read data (>=1)

Ports:
i_clk  in  1  single clock; memory ports A and B both run on it
i_rst_n  in  1  asynchronous active-low reset
i_req_valid_a  in  1  requester A request valid
o_req_ready_a  out  1  requester A request accepted this cycle
i_req_we_a  in  1  1=write, 0=read
i_req_addr_a  in  ADDR_WIDTH  requester A address
i_req_wdata_a  in  WIDTH  requester A write data
o_rvalid_a  out  1  read data valid for A
o_rdata_a  out  WIDTH  read data for A
i_req_valid_b, o_req_ready_b, i_req_we_b, i_req_addr_b, i_req_wdata_b, o_rvalid_b, o_rdata_b  same as A, for requester B
o_mem_en_a  out  1  memory port A enable
o_mem_we_a  out  1  memory port A write enable
o_mem_addr_a  out  ADDR_WIDTH  memory port A address
o_mem_din_a  out  WIDTH  memory port A write data
i_mem_dout_a  in  WIDTH  memory port A read data
o_mem_en_b, o_mem_we_b, o_mem_addr_b, o_mem_din_b, i_mem_dout_b  same as A, for memory port B

Behaviour:
- Bank of a request = addr[ADDR_WIDTH-1 -: log2(NUM_BANK)]. Conflict = both valid and banks equal.
- Priority register pri, states PRI_A and PRI_B. Reset value PRI_A.
- No conflict: o_req_ready_a = i_req_valid_a and o_req_ready_b = i_req_valid_b. Both requests are forwarded in the same cycle.
- Conflict: only the priority holder gets ready=1. The loser gets ready=0 and must hold its request stable.
- pri toggles on the clock edge after every conflict cycle (PRI_A->PRI_B or PRI_B->PRI_A). pri does not change on non-conflict cycles.
- Result: a persistent conflict alternates A,B,A,B. Maximum wait is 1 cycle.
- Ready is combinational from valid/addr/pri; there is no combinational path from ready to valid.
- Memory outputs are registered: an accepted request drives o_mem_* on the next cycle, for exactly 1 cycle.
  - o_mem_en_x=1, o_mem_we_x=we, addr and din copied from the request.
  - With no accept, en=0, we=0, and addr/din hold their last values.
- Read tracking: per port, a READ_LATENCY-deep shift register of read-issued flags, advanced every cycle.
  - o_rvalid_x=1 exactly READ_LATENCY cycles after o_mem_en_x=1 with we=0. Total 1+READ_LATENCY cycles after acceptance.
  - o_rdata_x = i_mem_dout_x in that cycle (pass-through). Otherwise o_rdata_x=0.
  - Writes never produce rvalid.
- Back-to-back reads are accepted every cycle with no bubbles. Responses on a port return in order.
- Same address on A and B in one cycle is always a conflict (same bank), so write-write and read-write collisions never reach the memory.
- Reset (asserted any time, including with reads in flight): all o_mem_* = 0, o_rvalid_* = 0, o_rdata_* = 0, pri=PRI_A. The read pipelines are cleared, so in-flight reads are dropped with no rvalid. Ready stays 0 while i_rst_n=0.

Optional Feature:
DPM_ARB_PERF_EN
- Defined: adds outputs o_conflict_cnt (16 bits) and o_stall_cnt_a / o_stall_cnt_b (16 bits each).
  - o_conflict_cnt increments on each conflict cycle.
  - o_stall_cnt_x increments on each cycle where i_req_valid_x=1 and o_req_ready_x=0.
  - All counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and their logic are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package dpm_arb_pkg: typedef pri_t enum {PRI_A, PRI_B}; localparam BANK_BITS = $clog2(NUM_BANK); function bank_of(addr).
- Sub-module dpm_rd_tracker (READ_LATENCY shift register plus rvalid/rdata mux), instantiated once per port.

Test Plan:
- Reset with valid A and B asserted -> ready 0, all o_mem_* 0, o_rvalid 0; on release pri=PRI_A.
- A write addr 0x03 data 0xA5, B read addr 0x1C (banks 0 and 3) in the same cycle -> both ready=1; next cycle en_a=1, we_a=1 and en_b=1, we_b=0; o_rvalid_b pulses 1+READ_LATENCY cycles after accept.
- A and B both read bank 1 (0x08, 0x0C), held for 4 cycles -> grant order A,B,A,B; stall 1 cycle on the losing side each time.
- A and B both write addr 0x10 with 0x11 and 0x22 -> A accepted first, B next cycle; memory sees two distinct single-port writes.
- A streams 8 back-to-back reads with READ_LATENCY=3 and the memory model returning addr^0x5A -> 8 consecutive rvalid cycles with data in issue order.
- Assert reset with 2 reads in flight -> no rvalid after release. With DPM_ARB_PERF_EN: 5 conflict cycles give o_conflict_cnt=5.
